dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the synchronous-read data memory (dmem).
- Requester 0 is the CPU load/store unit; requester 1 is the debug/DMA loader.
- Accepts at most one access per cycle and drives the dmem enable, read, write, address and data lines.
- Routes the one-cycle-latency read data back to the requester that issued the read.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_rr_arb2.sv | 33 +++
 rtl/dmem_arbiter.sv | 121 ++++++++++++
 tb/tb_dmem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types for the dmem arbiter: FSM state and requester ids.
// No logic; latency and backpressure are defined by the blocks that import it.
// Id encoding: 0 = CPU load/store unit, 1 = debug/DMA loader.
package dmem_arb_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ_CPU = 1'b0;
  localparam req_id_t REQ_DBG = 1'b1;

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way round-robin grant: the requester other than rr_last wins a conflict.
// Latency: purely combinational, zero cycles.
// Backpressure: the losing requester simply sees no grant and must hold its request.
module dmem_rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_vld,
  input  logic       rr_last,
  output logic [1:0] grant,
  output logic       grant_id
);

  always_comb begin
    grant    = 2'b00;
    grant_id = REQ_CPU;
    if (req_vld[0] && req_vld[1]) begin
      if (rr_last == REQ_CPU) begin
        grant    = 2'b10;
        grant_id = REQ_DBG;
      end else begin
        grant    = 2'b01;
        grant_id = REQ_CPU;
      end
    end else if (req_vld[1]) begin
      grant    = 2'b10;
      grant_id = REQ_DBG;
    end else if (req_vld[0]) begin
      grant    = 2'b01;
      grant_id = REQ_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester dmem arbiter/sequencer; DMEM_ARB_PERF_EN adds a saturating conflict counter.
// Latency: grant is combinational; read data returns exactly one cycle after acceptance.
// Backpressure: req_ready is the combinational round-robin grant, forced low during RESET.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  MEM_DEPTH  = 1024,
  localparam int ADDR_W     = $clog2(MEM_DEPTH)
) (
`ifdef DMEM_ARB_PERF_EN
  output logic [15:0]           conflict_cnt,
`endif
  input  logic                  clk,
  input  logic                  RESET,
  input  logic                  m0_req_valid,
  input  logic                  m1_req_valid,
  output logic                  m0_req_ready,
  output logic                  m1_req_ready,
  input  logic                  m0_req_we,
  input  logic                  m1_req_we,
  input  logic [ADDR_W-1:0]     m0_req_addr,
  input  logic [ADDR_W-1:0]     m1_req_addr,
  input  logic [DATA_WIDTH-1:0] m0_req_wdata,
  input  logic [DATA_WIDTH-1:0] m1_req_wdata,
  output logic                  m0_rsp_valid,
  output logic                  m1_rsp_valid,
  output logic [DATA_WIDTH-1:0] m0_rsp_rdata,
  output logic [DATA_WIDTH-1:0] m1_rsp_rdata,
  output logic                  mem_enable,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  arb_state_t            state, state_nxt;
  logic [1:0]            req_vld, grant;
  logic                  grant_id, rr_last, rsp_id;
  logic                  xfer, sel_we, rsp_vld;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Masking valids in reset keeps ready and every mem strobe low without extra gating.
  assign req_vld = RESET ? 2'b00 : {m1_req_valid, m0_req_valid};

  dmem_rr_arb2 u_rr_arb (
    .req_vld  (req_vld),
    .rr_last  (rr_last),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign m0_req_ready = grant[0];
  assign m1_req_ready = grant[1];
  assign xfer         = |grant;

  assign sel_we    = (grant_id == REQ_DBG) ? m1_req_we    : m0_req_we;
  assign sel_addr  = (grant_id == REQ_DBG) ? m1_req_addr  : m0_req_addr;
  assign sel_wdata = (grant_id == REQ_DBG) ? m1_req_wdata : m0_req_wdata;

  always_comb begin
    mem_enable = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (xfer) begin
      mem_enable = 1'b1;
      mem_write  = sel_we;
      mem_read   = !sel_we;
      mem_addr   = sel_addr;
      mem_wdata  = sel_wdata;
    end
  end

  always_comb begin
    state_nxt = state;
    rsp_vld   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (xfer && !sel_we) state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        rsp_vld   = 1'b1;
        state_nxt = (xfer && !sel_we) ? ST_RD_WAIT : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state   <= ST_IDLE;
      rr_last <= REQ_DBG;
      rsp_id  <= REQ_CPU;
    end else begin
      state <= state_nxt;
      if (xfer) rr_last <= grant_id;
      if (xfer && !sel_we) rsp_id <= grant_id;
    end
  end

  // A read left outstanding when RESET rises is dropped rather than returned.
  assign m0_rsp_valid = rsp_vld && !RESET && (rsp_id == REQ_CPU);
  assign m1_rsp_valid = rsp_vld && !RESET && (rsp_id == REQ_DBG);
  assign m0_rsp_rdata = m0_rsp_valid ? mem_dout : '0;
  assign m1_rsp_rdata = m1_rsp_valid ? mem_dout : '0;

`ifdef DMEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (RESET) begin
      conflict_cnt <= '0;
    end else if (m0_req_valid && m1_req_valid && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model (grant rule, shadow memory, pending read).
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          RESET = 1'b1;
  logic          m0_req_valid = 1'b0, m1_req_valid = 1'b0;
  logic          m0_req_we = 1'b0, m1_req_we = 1'b0;
  logic [AW-1:0] m0_req_addr = '0, m1_req_addr = '0;
  logic [DW-1:0] m0_req_wdata = '0, m1_req_wdata = '0;
  logic          m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid;
  logic [DW-1:0] m0_rsp_rdata, m1_rsp_rdata;
  logic          mem_enable, mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_dout;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0]   conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DATA_WIDTH(DW), .MEM_DEPTH(1024)) dut (
`ifdef DMEM_ARB_PERF_EN
    .conflict_cnt (conflict_cnt),
`endif
    .clk          (clk),
    .RESET        (RESET),
    .m0_req_valid (m0_req_valid),
    .m1_req_valid (m1_req_valid),
    .m0_req_ready (m0_req_ready),
    .m1_req_ready (m1_req_ready),
    .m0_req_we    (m0_req_we),
    .m1_req_we    (m1_req_we),
    .m0_req_addr  (m0_req_addr),
    .m1_req_addr  (m1_req_addr),
    .m0_req_wdata (m0_req_wdata),
    .m1_req_wdata (m1_req_wdata),
    .m0_rsp_valid (m0_rsp_valid),
    .m1_rsp_valid (m1_rsp_valid),
    .m0_rsp_rdata (m0_rsp_rdata),
    .m1_rsp_rdata (m1_rsp_rdata),
    .mem_enable   (mem_enable),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_dout     (mem_dout)
  );

  always #5 clk = ~clk;

  // Synchronous-read dmem; only addresses 0..15 are ever used. Backdoor port preloads it.
  logic          bd_we = 1'b0;
  logic [3:0]    bd_addr = '0;
  logic [DW-1:0] bd_data = '0;
  logic [DW-1:0] dmem [16];

  always @(posedge clk) begin
    if (bd_we) dmem[bd_addr] <= bd_data;
    if (mem_enable && mem_write) dmem[mem_addr[3:0]] <= mem_wdata;
    if (mem_enable && mem_read) mem_dout <= dmem[mem_addr[3:0]];
  end

  // Reference model: last winner, shadow memory, one pending read, conflict count.
  logic          ref_last = 1'b1;
  logic          pend_vld = 1'b0, pend_id = 1'b0;
  logic [DW-1:0] pend_data = '0;
  logic [15:0]   ref_cnt = '0;
  logic [DW-1:0] ref_mem [16];
  logic          e_rdy0, e_rdy1, e_rsp0, e_rsp1, e_en, e_rd, e_wr;
  logic [DW-1:0] e_rd0, e_rd1, e_wd;
  logic [AW-1:0] e_addr;

  task automatic model_eval();
    {e_rdy0, e_rdy1, e_rsp0, e_rsp1, e_en, e_rd, e_wr} = '0;
    e_rd0 = '0; e_rd1 = '0; e_wd = '0; e_addr = '0;
    if (!RESET) begin
      if (m0_req_valid && m1_req_valid) begin
        e_rdy0 = (ref_last == 1'b1);
        e_rdy1 = (ref_last == 1'b0);
      end else begin
        e_rdy0 = m0_req_valid;
        e_rdy1 = m1_req_valid;
      end
      if (pend_vld && pend_id == 1'b0) begin e_rsp0 = 1'b1; e_rd0 = pend_data; end
      if (pend_vld && pend_id == 1'b1) begin e_rsp1 = 1'b1; e_rd1 = pend_data; end
      if (e_rdy0) begin
        e_en = 1'b1; e_wr = m0_req_we; e_rd = !m0_req_we; e_addr = m0_req_addr; e_wd = m0_req_wdata;
      end else if (e_rdy1) begin
        e_en = 1'b1; e_wr = m1_req_we; e_rd = !m1_req_we; e_addr = m1_req_addr; e_wd = m1_req_wdata;
      end
    end
  endtask

  task automatic model_commit();
    if (RESET) begin
      ref_last = 1'b1; pend_vld = 1'b0; ref_cnt = '0;
    end else begin
      if (m0_req_valid && m1_req_valid && ref_cnt != 16'hFFFF) ref_cnt = ref_cnt + 16'd1;
      pend_vld = 1'b0;
      if (e_en) begin
        ref_last = e_rdy1;
        if (e_wr) ref_mem[e_addr[3:0]] = e_wd;
        else begin
          pend_vld = 1'b1; pend_id = e_rdy1; pend_data = ref_mem[e_addr[3:0]];
        end
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    m0_req_valid = 1'b0; m1_req_valid = 1'b0; m0_req_we = 1'b0; m1_req_we = 1'b0;
  endtask

  task automatic bd_write(input logic [3:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    sample();
    advance();
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    idle_inputs();
    sample(); advance();
    sample(); advance();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      checks++; if (m0_req_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy0: got %b want 0", m0_req_ready); end
      checks++; if (m1_req_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy1: got %b want 0", m1_req_ready); end
      checks++; if ({mem_enable, mem_read, mem_write} !== 3'b000) begin errors++; $display("FAIL reset_mem_strobes: got %b want 000", {mem_enable, mem_read, mem_write}); end
      checks++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp: got %b want 00", {m0_rsp_valid, m1_rsp_valid}); end
`ifdef DMEM_ARB_PERF_EN
      if (i == 1) begin
        checks++; if (conflict_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", conflict_cnt); end
      end
`endif
      advance();
    end
    RESET = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_read();
    bd_write(4'd5, 32'hDEAD_BEEF);
    m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_addr = 10'd5;
    sample();
    checks++; if (m0_req_ready !== 1'b1) begin errors++; $display("FAIL single_rdy: got %b want 1", m0_req_ready); end
    checks++; if ({mem_enable, mem_read, mem_write, mem_addr} !== {3'b110, 10'd5}) begin errors++; $display("FAIL single_mem: got %b want %b", {mem_enable, mem_read, mem_write, mem_addr}, {3'b110, 10'd5}); end
    advance();
    idle_inputs();
    sample();
    checks++; if (m0_rsp_valid !== 1'b1 || m0_rsp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rsp: got %b/%h want 1/deadbeef", m0_rsp_valid, m0_rsp_rdata); end
    checks++; if (m1_rsp_valid !== 1'b0 || m1_rsp_rdata !== '0) begin errors++; $display("FAIL single_other: got %b/%h want 0/0", m1_rsp_valid, m1_rsp_rdata); end
    advance();
    sample();
    checks++; if (m0_rsp_valid !== 1'b0 || m0_rsp_rdata !== '0) begin errors++; $display("FAIL single_pulse: got %b/%h want 0/0", m0_rsp_valid, m0_rsp_rdata); end
    advance();
  endtask

  task automatic test_conflict();
    bd_write(4'd1, 32'hA1A1_0001);
    bd_write(4'd2, 32'hB2B2_0002);
    do_reset();
    m0_req_valid = 1'b1; m0_req_addr = 10'd1;
    m1_req_valid = 1'b1; m1_req_addr = 10'd2;
    sample();
    checks++; if ({m0_req_ready, m1_req_ready} !== 2'b10) begin errors++; $display("FAIL conflict_c0: got %b want 10", {m0_req_ready, m1_req_ready}); end
    advance();
    m0_req_valid = 1'b0;
    sample();
    checks++; if (m1_req_ready !== 1'b1) begin errors++; $display("FAIL conflict_c1_rdy: got %b want 1", m1_req_ready); end
    checks++; if (m0_rsp_valid !== 1'b1 || m0_rsp_rdata !== 32'hA1A1_0001) begin errors++; $display("FAIL conflict_c1_rsp: got %b/%h want 1/a1a10001", m0_rsp_valid, m0_rsp_rdata); end
    advance();
    idle_inputs();
    sample();
    checks++; if (m1_rsp_valid !== 1'b1 || m1_rsp_rdata !== 32'hB2B2_0002 || m0_rsp_valid !== 1'b0) begin errors++; $display("FAIL conflict_c2_rsp: got %b/%h/%b want 1/b2b20002/0", m1_rsp_valid, m1_rsp_rdata, m0_rsp_valid); end
    advance();
  endtask

  task automatic test_sustained();
    do_reset();
    m0_req_valid = 1'b1; m0_req_addr = 10'd3;
    m1_req_valid = 1'b1; m1_req_addr = 10'd4;
    for (int i = 0; i < 6; i++) begin
      sample();
      checks++; if ({m0_req_ready, m1_req_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL sustained_grant%0d: got %b want %b", i, {m0_req_ready, m1_req_ready}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      advance();
    end
    idle_inputs();
    sample();
`ifdef DMEM_ARB_PERF_EN
    checks++; if (conflict_cnt !== 16'd6) begin errors++; $display("FAIL sustained_cnt: got %0d want 6", conflict_cnt); end
`endif
    checks++; if (m1_rsp_valid !== 1'b1) begin errors++; $display("FAIL sustained_last_rsp: got %b want 1", m1_rsp_valid); end
    advance();
  endtask

  task automatic test_write_then_read();
    int wr_pulses = 0;
    m1_req_valid = 1'b1; m1_req_we = 1'b1; m1_req_addr = 10'd7; m1_req_wdata = 32'h1234_5678;
    sample();
    wr_pulses += int'(mem_write);
    checks++; if ({m1_req_ready, mem_addr, mem_wdata} !== {1'b1, 10'd7, 32'h1234_5678}) begin errors++; $display("FAIL wr_drive: got %b/%0d/%h want 1/7/12345678", m1_req_ready, mem_addr, mem_wdata); end
    checks++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) begin errors++; $display("FAIL wr_no_rsp: got %b want 00", {m0_rsp_valid, m1_rsp_valid}); end
    advance();
    m1_req_we = 1'b0;
    sample();
    wr_pulses += int'(mem_write);
    checks++; if ({m1_req_ready, mem_read} !== 2'b11) begin errors++; $display("FAIL raw_read_issue: got %b want 11", {m1_req_ready, mem_read}); end
    checks++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) begin errors++; $display("FAIL wr_no_rsp_next: got %b want 00", {m0_rsp_valid, m1_rsp_valid}); end
    advance();
    idle_inputs();
    sample();
    wr_pulses += int'(mem_write);
    checks++; if (m1_rsp_valid !== 1'b1 || m1_rsp_rdata !== 32'h1234_5678) begin errors++; $display("FAIL raw_rsp: got %b/%h want 1/12345678", m1_rsp_valid, m1_rsp_rdata); end
    checks++; if (wr_pulses != 1) begin errors++; $display("FAIL wr_pulses: got %0d want 1", wr_pulses); end
    advance();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) bd_write(4'(k), 32'h1111_1111 * (k + 1));
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin m0_req_valid = 1'b1; m0_req_addr = 10'(k); end
      else idle_inputs();
      sample();
      if (k < 4) begin
        checks++; if (m0_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_rdy%0d: got %b want 1", k, m0_req_ready); end
      end
      if (k > 0) begin
        checks++; if (m0_rsp_valid !== 1'b1 || m0_rsp_rdata !== 32'h1111_1111 * k) begin errors++; $display("FAIL b2b_rsp%0d: got %b/%h want 1/%h", k, m0_rsp_valid, m0_rsp_rdata, 32'h1111_1111 * k); end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_read();
    m0_req_valid = 1'b1; m0_req_addr = 10'd5;
    sample();
    checks++; if (m0_req_ready !== 1'b1) begin errors++; $display("FAIL midrst_accept: got %b want 1", m0_req_ready); end
    advance();
    idle_inputs();
    RESET = 1'b1;
    sample();
    checks++; if ({m0_rsp_valid, m0_rsp_rdata, mem_enable} !== {1'b0, 32'h0, 1'b0}) begin errors++; $display("FAIL midrst_drop: got %b/%h/%b want 0/0/0", m0_rsp_valid, m0_rsp_rdata, mem_enable); end
    advance();
    RESET = 1'b0;
    sample();
    checks++; if ({m0_rsp_valid, m1_rsp_valid} !== 2'b00) begin errors++; $display("FAIL midrst_after: got %b want 00", {m0_rsp_valid, m1_rsp_valid}); end
    advance();
    m0_req_valid = 1'b1; m1_req_valid = 1'b1; m0_req_addr = 10'd1; m1_req_addr = 10'd2;
    sample();
    checks++; if ({m0_req_ready, m1_req_ready} !== 2'b10) begin errors++; $display("FAIL midrst_first_conflict: got %b want 10", {m0_req_ready, m1_req_ready}); end
    advance();
    m0_req_valid = 1'b0;
    sample();
    advance();
    idle_inputs();
    sample();
    advance();
  endtask

  task automatic test_random();
    for (int a = 0; a < 16; a++) bd_write(4'(a), $urandom);
    for (int c = 0; c < 400; c++) begin
      sample();
      checks++; if ({m0_req_ready, m1_req_ready} !== {e_rdy0, e_rdy1}) begin errors++; $display("FAIL rand_rdy c%0d: got %b want %b", c, {m0_req_ready, m1_req_ready}, {e_rdy0, e_rdy1}); end
      checks++; if ({mem_enable, mem_read, mem_write, mem_addr, mem_wdata} !== {e_en, e_rd, e_wr, e_addr, e_wd}) begin errors++; $display("FAIL rand_mem c%0d: got %b/%0d/%h want %b/%0d/%h", c, {mem_enable, mem_read, mem_write}, mem_addr, mem_wdata, {e_en, e_rd, e_wr}, e_addr, e_wd); end
      checks++; if ({m0_rsp_valid, m0_rsp_rdata} !== {e_rsp0, e_rd0}) begin errors++; $display("FAIL rand_rsp0 c%0d: got %b/%h want %b/%h", c, m0_rsp_valid, m0_rsp_rdata, e_rsp0, e_rd0); end
      checks++; if ({m1_rsp_valid, m1_rsp_rdata} !== {e_rsp1, e_rd1}) begin errors++; $display("FAIL rand_rsp1 c%0d: got %b/%h want %b/%h", c, m1_rsp_valid, m1_rsp_rdata, e_rsp1, e_rd1); end
`ifdef DMEM_ARB_PERF_EN
      checks++; if (conflict_cnt !== ref_cnt) begin errors++; $display("FAIL rand_cnt c%0d: got %0d want %0d", c, conflict_cnt, ref_cnt); end
`endif
      advance();
      // A requester only changes its request once the previous one was taken.
      if (!m0_req_valid || e_rdy0) begin
        m0_req_valid = ($urandom_range(0, 3) != 0);
        m0_req_we = $urandom_range(0, 1) == 1; m0_req_addr = 10'($urandom_range(0, 15)); m0_req_wdata = $urandom;
      end
      if (!m1_req_valid || e_rdy1) begin
        m1_req_valid = ($urandom_range(0, 3) != 0);
        m1_req_we = $urandom_range(0, 1) == 1; m1_req_addr = 10'($urandom_range(0, 15)); m1_req_wdata = $urandom;
      end
    end
    idle_inputs();
    sample();
    advance();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_conflict();
    test_sustained();
    test_write_then_read();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
